// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields plus a full 32-bit immediate into an instruction word,
// behind a one-deep registered output stage. Optional macro ENCODER_ERROR_NOP_EN forces NOP on range errors.
module instruction_encoder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             format,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [31:0]            immediate,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instruction,
  output logic [ADDR_WIDTH-1:0]  out_address,
  output logic                   range_error,
  output logic [COUNT_WIDTH-1:0] error_count
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } format_e;

  localparam logic [31:0]            NOP_WORD  = 32'h00000013;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  format_e                w_format;
  logic                   w_fits12;
  logic                   w_fits13;
  logic                   w_fits21;
  logic [31:0]            w_packed;
  logic [31:0]            w_encoded;
  logic                   w_rangeErr;
  logic                   w_inFire;
  logic                   w_outFire;

  logic                   r_outValid;
  logic [31:0]            r_instruction;
  logic [ADDR_WIDTH-1:0]  r_address;
  logic                   r_rangeErr;
  logic [COUNT_WIDTH-1:0] r_errorCount;

  assign w_format = format_e'(format);

  // A value fits an N-bit signed slot when every bit above the sign bit copies it.
  assign w_fits12 = (&immediate[31:11]) | ~(|immediate[31:11]);
  assign w_fits13 = (&immediate[31:12]) | ~(|immediate[31:12]);
  assign w_fits21 = (&immediate[31:20]) | ~(|immediate[31:20]);

  always_comb begin
    w_packed   = NOP_WORD;
    w_rangeErr = 1'b0;
    unique case (w_format)
      FMT_R: begin
        w_packed = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        w_packed   = {immediate[11:0], rs1, funct3, rd, opcode};
        w_rangeErr = ~w_fits12;
      end
      FMT_S: begin
        w_packed   = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
        w_rangeErr = ~w_fits12;
      end
      FMT_B: begin
        w_packed   = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                      immediate[4:1], immediate[11], opcode};
        w_rangeErr = ~w_fits13 | immediate[0];
      end
      FMT_U: begin
        w_packed   = {immediate[31:12], rd, opcode};
        w_rangeErr = |immediate[11:0];
      end
      FMT_J: begin
        w_packed   = {immediate[20], immediate[10:1], immediate[11],
                      immediate[19:12], rd, opcode};
        w_rangeErr = ~w_fits21 | immediate[0];
      end
      FMT_BAD6, FMT_BAD7: begin
        w_packed   = NOP_WORD;
        w_rangeErr = 1'b1;
      end
      default: begin
        w_packed   = NOP_WORD;
        w_rangeErr = 1'b1;
      end
    endcase
  end

`ifdef ENCODER_ERROR_NOP_EN
  assign w_encoded = w_rangeErr ? NOP_WORD : w_packed;
`else
  assign w_encoded = w_packed;
`endif

  assign in_ready  = ~r_outValid | out_ready;
  assign w_inFire  = in_valid & in_ready;
  assign w_outFire = r_outValid & out_ready;

  // Output stage: a new beat may load in the same cycle the old one drains.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid    <= 1'b0;
      r_instruction <= '0;
      r_address     <= '0;
      r_rangeErr    <= 1'b0;
      r_errorCount  <= '0;
    end else begin
      if (w_inFire) begin
        r_outValid    <= 1'b1;
        r_instruction <= w_encoded;
        r_rangeErr    <= w_rangeErr;
      end else if (w_outFire) begin
        r_outValid <= 1'b0;
      end
      if (w_outFire) begin
        r_address <= r_address + ADDR_ONE;
      end
      if (w_inFire && w_rangeErr && (r_errorCount != '1)) begin
        r_errorCount <= r_errorCount + COUNT_ONE;
      end
    end
  end

  assign out_valid       = r_outValid;
  assign out_instruction = r_instruction;
  assign out_address     = r_address;
  assign range_error     = r_rangeErr;
  assign error_count     = r_errorCount;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: a driver pushes reference-model results,
// a negedge monitor pops and compares whenever the DUT presents a beat.
module tb_instruction_encoder;

  localparam int AW = 4;
  localparam int CW = 8;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    format;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   immediate;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instruction;
  logic [AW-1:0] out_address;
  logic          range_error;
  logic [CW-1:0] error_count;

  typedef struct {
    logic [31:0] word;
    logic        err;
    int          addr;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   beatIdx = 0;
  int   modelErrCnt = 0;

  instruction_encoder #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .format(format), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_address(out_address),
    .range_error(range_error), .error_count(error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference model: ranges as plain signed arithmetic, fields placed from the RV32I tables.
  function automatic exp_t refModel(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                    input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] imm);
    exp_t e;
    int   v;
    v = $signed(imm);
    e.addr = 0;
    case (f)
      3'd0: begin e.word = {f7, s2, s1, f3, d, op}; e.err = 1'b0; end
      3'd1: begin e.word = {imm[11:0], s1, f3, d, op}; e.err = (v < -2048) || (v > 2047); end
      3'd2: begin e.word = {imm[11:5], s2, s1, f3, imm[4:0], op}; e.err = (v < -2048) || (v > 2047); end
      3'd3: begin
        e.word = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], op};
        e.err  = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin e.word = {imm[31:12], d, op}; e.err = (v % 4096) != 0; end
      3'd5: begin
        e.word = {imm[20], imm[10:1], imm[11], imm[19:12], d, op};
        e.err  = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin e.word = 32'h00000013; e.err = 1'b1; end
    endcase
`ifdef ENCODER_ERROR_NOP_EN
    if (e.err) e.word = 32'h00000013;
`endif
    return e;
  endfunction

  // Drives one cycle of input; on acceptance pushes the expected beat after the loading edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input bit useConst, input logic [31:0] cWord, input bit cErr,
                               output bit accepted);
    exp_t e;
    in_valid = 1'b1; format = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; immediate = imm;
    e = refModel(f, op, d, s1, s2, f3, f7, imm);
    if (useConst) begin
      e.word = cWord;
      e.err  = cErr;
    end
    @(negedge clock);
    accepted = in_ready;
    @(posedge clock);
    #1;
    if (accepted) begin
      e.addr = beatIdx % (1 << AW);
      sbQ.push_back(e);
      beatIdx++;
      if (e.err && modelErrCnt < 255) modelErrCnt++;
    end
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic sendDirected(input string name, input logic [2:0] f, input logic [6:0] op,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] f3, input logic [31:0] imm,
                              input logic [31:0] cWord, input bit cErr);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++)
      applyStimulus(f, op, d, s1, s2, f3, 7'h00, imm, 1'b1, cWord, cErr, acc);
    if (!acc) begin
      total++; bad++;
      $display("[TB] FAIL %s_accept_timeout actual=0 required=1", name);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] randImm();
    int pick;
    logic [31:0] table_v [16];
    table_v = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, 32'd4096,
                -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048575, 32'd1048576,
                -32'sd1048576, -32'sd1048578, 32'h0, 32'hFFFFF000};
    pick = $urandom_range(0, 19);
    if (pick < 16) return table_v[pick];
    if (pick == 16) return $urandom() & 32'hFFFFF000;
    if (pick == 17) return $urandom();
    return 32'($signed($urandom_range(0, 8000)) - 4000);
  endfunction

  // Monitor: compares presented beats with the scoreboard front and checks handshake/counter state.
  always @(negedge clock) begin
    if (reset_n) begin
      bit expValid;
      expValid = (sbQ.size() != 0);
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expValid});
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!expValid || out_ready)});
      checkOutput("error_count", {24'b0, error_count}, 32'(modelErrCnt));
      if (expValid && out_valid) begin
        checkOutput("out_instruction", out_instruction, sbQ[0].word);
        checkOutput("out_address", {28'b0, out_address}, 32'(sbQ[0].addr));
        checkOutput("range_error", {31'b0, range_error}, {31'b0, sbQ[0].err});
        if (out_ready) void'(sbQ.pop_front());
      end
    end
  end

`ifdef ENCODER_ERROR_NOP_EN
  localparam logic [31:0] LUI_ERR_WORD = 32'h00000013;
  localparam logic [31:0] BEQ_ERR_WORD = 32'h00000013;
  localparam logic [31:0] I2048_WORD   = 32'h00000013;
`else
  localparam logic [31:0] LUI_ERR_WORD = 32'hFFFFF037;
  localparam logic [31:0] BEQ_ERR_WORD = 32'hFE208EE3;
  localparam logic [31:0] I2048_WORD   = 32'h80002103;
`endif

  initial begin
    bit acc;
    int drained;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    format = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; immediate = '0;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_out_instruction", out_instruction, 32'h0);
    checkOutput("reset_out_address", {28'b0, out_address}, 32'h0);
    checkOutput("reset_range_error", {31'b0, range_error}, 32'h0);
    checkOutput("reset_error_count", {24'b0, error_count}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    idleCycle();

    $display("[TB] directed encodings");
    sendDirected("lw", 3'd1, 7'h03, 5'd2, 5'd0, 5'd0, 3'd2, 32'h60, 32'h06002103, 1'b0);
    sendDirected("lui", 3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFF000, 32'hFFFFF037, 1'b0);
    sendDirected("lui_err", 3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFF001, LUI_ERR_WORD, 1'b1);
    sendDirected("beq", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    sendDirected("beq_err", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFD, BEQ_ERR_WORD, 1'b1);
    sendDirected("i2048", 3'd1, 7'h03, 5'd2, 5'd0, 5'd0, 3'd2, 32'd2048, I2048_WORD, 1'b1);
    sendDirected("fmt7", 3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0, 32'h00000013, 1'b1);
    repeat (3) idleCycle();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(3'd0, 7'h33, 5'(i), 5'(i + 1), 5'(i + 2), 3'd0, 7'h20, 32'h0, 1'b0, 32'h0, 1'b0, acc);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(3'd2, 7'h23, 5'd0, 5'(i), 5'(i + 7), 3'd2, 7'h00, 32'(i * 4), 1'b0, 32'h0, 1'b0, acc);
    idleCycle();

    $display("[TB] address wrap");
    for (int i = 0; i < 20; i++)
      applyStimulus(3'd1, 7'h13, 5'(i), 5'(i), 5'd0, 3'd0, 7'h00, 32'(i), 1'b0, 32'h0, 1'b0, acc);
    idleCycle();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0)
        applyStimulus(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()), 5'($urandom()),
                      5'($urandom()), 3'($urandom()), 7'($urandom()), randImm(),
                      1'b0, 32'h0, 1'b0, acc);
      else
        idleCycle();
    end
    out_ready = 1'b1;
    idleCycle();

    $display("[TB] mid-stream reset");
    out_ready = 1'b0;
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 1'b0, 32'h0, 1'b0, acc);
    in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("async_reset_out_address", {28'b0, out_address}, 32'h0);
    checkOutput("async_reset_error_count", {24'b0, error_count}, 32'h0);
    sbQ.delete();
    beatIdx = 0;
    modelErrCnt = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    repeat (3) idleCycle();

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++)
      applyStimulus(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0, 1'b0, acc);
    idleCycle();
    checkOutput("error_count_saturated", {24'b0, error_count}, 32'd255);

    drained = 0;
    for (int t = 0; t < 20 && !drained; t++) begin
      if (sbQ.size() == 0) drained = 1;
      else idleCycle();
    end
    if (!drained) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Inverse of the CPU immediate generator. Accepts decoded RV32I fields plus a full 32-bit immediate and packs them into a 32-bit instruction word, scattering the immediate bits per format (R/I/S/B/U/J). It has a one-deep registered output stage with valid/ready handshakes on both sides. It also has an auto-incrementing write address, so it can stream assembled programs into instruction memory for bench and loader use.

Parameters:
ADDR_WIDTH, 8, width of the output word-address counter; wraps modulo 2^ADDR_WIDTH.
COUNT_WIDTH, 8, width of the saturating range-error counter.

Ports:
clock  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  input fields valid.
in_ready  output  1  encoder can accept a beat.
format  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
opcode  input  7  instruction bits [6:0].
rd  input  5  destination register.
rs1  input  5  source register 1.
rs2  input  5  source register 2.
funct3  input  3  function field.
funct7  input  7  function field (R only).
immediate  input  32  sign-extended byte offset or value (U: upper 20 bits in [31:12]).
out_valid  output  1  out_instruction valid.
out_ready  input  1  downstream accepts.
out_instruction  output  32  encoded word.
out_address  output  ADDR_WIDTH  word address for this beat.
range_error  output  1  qualifies the current output beat; immediate or format illegal.
error_count  output  COUNT_WIDTH  saturating count of accepted error beats.

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_instruction=0, out_address=0, range_error=0, error_count=0. in_ready=1 once reset is released.
- Reset during a pending beat discards that beat. No partial output appears.
- in_ready = !out_valid || out_ready (combinational).
- An input handshake (in_valid && in_ready) registers the encoded word. Latency is one cycle: out_valid is high on the next edge.
- Output handshake (out_valid && out_ready):
  - out_address increments by 1 and wraps from 2^ADDR_WIDTH-1 to 0.
  - If in_valid is also high the same cycle, the new beat loads with no bubble.
- While out_valid && !out_ready: out_instruction, out_address and range_error hold stable.
- Encoding (standard RV32I bit placement):
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range check sets range_error for the beat:
  - I/S: immediate outside [-2048, 2047].
  - B: outside [-4096, 4094], or imm[0]=1.
  - U: imm[11:0] != 0.
  - J: outside [-1048576, 1048574], or imm[0]=1.
  - R: immediate ignored, never an error.
  - Format 6/7: always an error, and the word is forced to 32'h00000013.
- error_count increments on each input handshake carrying an error and saturates at all-ones.

Optional Feature:
Macro ENCODER_ERROR_NOP_EN.
- Defined: any beat with range_error=1 outputs 32'h00000013 (addi x0,x0,0).
- Undefined: the out-of-range immediate is truncated to the format's bit slots and encoded as-is. range_error still asserts.
- Format 6/7 outputs NOP in both builds.

Test Plan:
- I-type lw: format=1, op=7'h03, rd=2, rs1=0, f3=2, imm=32'h60, out_ready=1 → next cycle out_instruction=32'h06002103, out_address=0, range_error=0.
- U-type lui: format=4, op=7'h37, rd=0, imm=32'hFFFFF000 → 32'hFFFFF037, out_address=1. Then imm=32'hFFFFF001 → range_error=1, error_count=1.
- B-type beq x1,x2,-4: format=3, op=7'h63, rs1=1, rs2=2, f3=0, imm=32'hFFFFFFFC → 32'hFE208EE3. Then imm=32'hFFFFFFFD → range_error=1.
- I-type imm=2048:
  - Without macro: range_error=1, out_instruction[31:20]=12'h800.
  - With ENCODER_ERROR_NOP_EN: 32'h00000013.
  - error_count saturates at 255 after 300 error beats.
- Backpressure: out_ready=0 with in_valid=1 for 5 cycles → one beat captured, in_ready=0, outputs stable. Releasing out_ready drains back-to-back with no bubble, and the address increments once per handshake.
- ADDR_WIDTH=4: 17 beats → the 17th beat has out_address=0. Assert reset_n=0 mid-stream → out_valid=0 and out_address=0 immediately (async), with no stale beat after release.
